// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster timing block.
// Holds the default 640x480@60 timing numbers, the counter type and the
// pure decode functions used for sync and visible-area generation.
package vga_timing_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  // Default 640x480@60 timing (pixels / lines).
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Sync pulse boundaries for the default timing: [start, end).
  localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  // 1 when (h,v) lies inside the visible window.
  function automatic logic is_visible(cnt_t h, cnt_t v, int h_vis, int v_vis);
    return (int'(h) < h_vis) && (int'(v) < v_vis);
  endfunction

  // Active-low horizontal sync: low inside [sync_start, sync_end).
  function automatic logic hsync_n(cnt_t h, int sync_start, int sync_end);
    return !((int'(h) >= sync_start) && (int'(h) < sync_end));
  endfunction

  // Active-low vertical sync: low inside [sync_start, sync_end).
  function automatic logic vsync_n(cnt_t v, int sync_start, int sync_end);
    return !((int'(v) >= sync_start) && (int'(v) < sync_end));
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Scan-side bundle produced by vga_timing_gen.
//   master : the timing source (drives everything)
//   slave  : pixel pipeline / pins (samples everything)
// Signals: pix_tick, hCount, vCount, hSync, vSync, bright,
//          fetch_h, fetch_v, fetch_valid, line_tick, vblank_tick, frame_tick.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic pix_tick;
  cnt_t hCount;
  cnt_t vCount;
  logic hSync;
  logic vSync;
  logic bright;
  cnt_t fetch_h;
  cnt_t fetch_v;
  logic fetch_valid;
  logic line_tick;
  logic vblank_tick;
  logic frame_tick;

  modport master (
    output pix_tick, hCount, vCount, hSync, vSync, bright,
           fetch_h, fetch_v, fetch_valid, line_tick, vblank_tick, frame_tick
  );

  modport slave (
    input  pix_tick, hCount, vCount, hSync, vSync, bright,
           fetch_h, fetch_v, fetch_valid, line_tick, vblank_tick, frame_tick
  );

endinterface

// File: rtl/vga_timing_gen_pix_tick_gen.sv
// Pixel-enable divider.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset (divider phase -> 0)
//   pix_tick out high on the last clk of each CLK_DIV-clk pixel period
// With CLK_DIV=1 the divider register never leaves 0 and pix_tick is
// constantly high.
module pix_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= '0;
    end else if (div_reg == DIV_LAST) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  // Pure decode of the phase register so counters advance at the end of
  // exactly this clk.
  assign pix_tick = (div_reg == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source.
// Ports:
//   clk  in  system clock, all state on posedge
//   rst  in  synchronous active-high reset
//   vga  master modport of vga_timing_gen_if:
//        pix_tick, hCount/vCount raster position, hSync/vSync (active-low,
//        registered), bright (registered visible flag), fetch_h/fetch_v/
//        fetch_valid look-ahead position PREFETCH pixels ahead, and the
//        one-clk line_tick / vblank_tick / frame_tick event pulses.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int PREFETCH  = 2
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL    = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START   = H_VISIBLE + H_FP;
  localparam int HS_END     = HS_START + H_SYNC;
  localparam int VS_START   = V_VISIBLE + V_FP;
  localparam int VS_END     = VS_START + V_SYNC;
  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t VIS_LAST = cnt_t'(V_VISIBLE - 1);

  logic pix_tick;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (pix_tick)
  );

  cnt_t h_reg;
  cnt_t v_reg;
  cnt_t h_next;
  cnt_t v_next;
  logic hsync_reg;
  logic vsync_reg;
  logic bright_reg;
  logic h_last;
  logic v_last;

  assign h_last = (h_reg == H_LAST);
  assign v_last = (v_reg == V_LAST);

  // Next raster position; only moves on a pixel enable.
  always_comb begin
    h_next = h_reg;
    v_next = v_reg;
    if (pix_tick) begin
      if (h_last) begin
        h_next = '0;
        v_next = v_last ? '0 : v_reg + cnt_t'(1);
      end else begin
        h_next = h_reg + cnt_t'(1);
      end
    end
  end

  // Sync/bright are decoded from the next position so that they update on
  // the same edge as the counters instead of lagging by one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_reg      <= '0;
      v_reg      <= '0;
      hsync_reg  <= hsync_n('0, HS_START, HS_END);
      vsync_reg  <= vsync_n('0, VS_START, VS_END);
      bright_reg <= is_visible('0, '0, H_VISIBLE, V_VISIBLE);
    end else begin
      h_reg      <= h_next;
      v_reg      <= v_next;
      hsync_reg  <= hsync_n(h_next, HS_START, HS_END);
      vsync_reg  <= vsync_n(v_next, VS_START, VS_END);
      bright_reg <= is_visible(h_next, v_next, H_VISIBLE, V_VISIBLE);
    end
  end

  // Look-ahead position: one extra bit on the sum so columns past the end
  // of the line fold into the next line (and the last line into line 0).
  logic [CNT_W:0] fetch_sum;
  cnt_t           fetch_h;
  cnt_t           fetch_v;

  always_comb begin
    fetch_sum = {1'b0, h_reg} + (CNT_W+1)'(PREFETCH);
    fetch_h   = cnt_t'(fetch_sum);
    fetch_v   = v_reg;
    if (fetch_sum >= (CNT_W+1)'(H_TOTAL)) begin
      fetch_h = cnt_t'(fetch_sum - (CNT_W+1)'(H_TOTAL));
      fetch_v = v_last ? '0 : v_reg + cnt_t'(1);
    end
  end

  logic line_tick;

  assign line_tick = pix_tick && h_last;

  assign vga.pix_tick    = pix_tick;
  assign vga.hCount      = h_reg;
  assign vga.vCount      = v_reg;
  assign vga.hSync       = hsync_reg;
  assign vga.vSync       = vsync_reg;
  assign vga.bright      = bright_reg;
  assign vga.fetch_h     = fetch_h;
  assign vga.fetch_v     = fetch_v;
  assign vga.fetch_valid = is_visible(fetch_h, fetch_v, H_VISIBLE, V_VISIBLE);
  assign vga.line_tick   = line_tick;
  assign vga.vblank_tick = line_tick && (v_reg == VIS_LAST);
  assign vga.frame_tick  = line_tick && v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // full: real 640x480 timing; fast: tiny raster, CLK_DIV=1, PREFETCH=0;
  // wrap: tiny raster, CLK_DIV=3, PREFETCH=2 (frame wrap of look-ahead).
  vga_timing_gen_if if_full();
  vga_timing_gen_if if_fast();
  vga_timing_gen_if if_wrap();

  vga_timing_gen #(
    .CLK_DIV(4), .H_VISIBLE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_VISIBLE(480), .V_FP(10), .V_SYNC(2), .V_BP(33), .PREFETCH(2)
  ) u_full (.clk(clk), .rst(rst), .vga(if_full));

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PREFETCH(0)
  ) u_fast (.clk(clk), .rst(rst), .vga(if_fast));

  vga_timing_gen #(
    .CLK_DIV(3), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PREFETCH(2)
  ) u_wrap (.clk(clk), .rst(rst), .vga(if_wrap));

  typedef struct {
    int cd; int hv; int hfp; int hs; int hbp;
    int vv; int vfp; int vs; int vbp; int pf;
  } cfg_t;

  typedef struct packed {
    logic       pix;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
    logic [9:0] fh;
    logic [9:0] fv;
    logic       fvalid;
    logic       lt;
    logic       vbt;
    logic       ft;
  } obs_t;

  typedef struct packed {
    logic [1:0] d;
    obs_t       e;
  } item_t;

  typedef struct { int d; int h; int v; int fh; int fv; int fval; } vec_t;

  cfg_t  cfgs [3];
  obs_t  obs_a [3];
  item_t sb_q [$];
  vec_t  vecs [$];
  bit    seen [16];
  string dut_name [3] = '{"full", "fast", "wrap"};

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;
  bit armed    = 1'b0;
  logic rst_q;

  assign obs_a[0] = {if_full.pix_tick, if_full.hCount, if_full.vCount, if_full.hSync,
                     if_full.vSync, if_full.bright, if_full.fetch_h, if_full.fetch_v,
                     if_full.fetch_valid, if_full.line_tick, if_full.vblank_tick, if_full.frame_tick};
  assign obs_a[1] = {if_fast.pix_tick, if_fast.hCount, if_fast.vCount, if_fast.hSync,
                     if_fast.vSync, if_fast.bright, if_fast.fetch_h, if_fast.fetch_v,
                     if_fast.fetch_valid, if_fast.line_tick, if_fast.vblank_tick, if_fast.frame_tick};
  assign obs_a[2] = {if_wrap.pix_tick, if_wrap.hCount, if_wrap.vCount, if_wrap.hSync,
                     if_wrap.vSync, if_wrap.bright, if_wrap.fetch_h, if_wrap.fetch_v,
                     if_wrap.fetch_valid, if_wrap.line_tick, if_wrap.vblank_tick, if_wrap.frame_tick};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs t clks after the last reset edge, worked out from the
  // absolute pixel index rather than by stepping counters.
  function automatic obs_t model(cfg_t c, int tt);
    obs_t e;
    int ht, vt, div, p, h, v, q, qh, qv;
    ht  = c.hv + c.hfp + c.hs + c.hbp;
    vt  = c.vv + c.vfp + c.vs + c.vbp;
    div = tt % c.cd;
    p   = tt / c.cd;
    h   = p % ht;
    v   = (p / ht) % vt;
    q   = p + c.pf;
    qh  = q % ht;
    qv  = (q / ht) % vt;
    e.pix    = (div == c.cd - 1);
    e.h      = 10'(h);
    e.v      = 10'(v);
    e.hs     = !((h >= c.hv + c.hfp) && (h < c.hv + c.hfp + c.hs));
    e.vs     = !((v >= c.vv + c.vfp) && (v < c.vv + c.vfp + c.vs));
    e.br     = (h < c.hv) && (v < c.vv);
    e.fh     = 10'(qh);
    e.fv     = 10'(qv);
    e.fvalid = (qh < c.hv) && (qv < c.vv);
    e.lt     = e.pix && (h == ht - 1);
    e.vbt    = e.lt && (v == c.vv - 1);
    e.ft     = e.lt && (v == vt - 1);
    return e;
  endfunction

  task automatic cmp(int d, obs_t e, obs_t a);
    string p;
    p = dut_name[d];
    chk({p, ".pix_tick"},    32'(a.pix),    32'(e.pix));
    chk({p, ".hCount"},      32'(a.h),      32'(e.h));
    chk({p, ".vCount"},      32'(a.v),      32'(e.v));
    chk({p, ".hSync"},       32'(a.hs),     32'(e.hs));
    chk({p, ".vSync"},       32'(a.vs),     32'(e.vs));
    chk({p, ".bright"},      32'(a.br),     32'(e.br));
    chk({p, ".fetch_h"},     32'(a.fh),     32'(e.fh));
    chk({p, ".fetch_v"},     32'(a.fv),     32'(e.fv));
    chk({p, ".fetch_valid"}, 32'(a.fvalid), 32'(e.fvalid));
    chk({p, ".line_tick"},   32'(a.lt),     32'(e.lt));
    chk({p, ".vblank_tick"}, 32'(a.vbt),    32'(e.vbt));
    chk({p, ".frame_tick"},  32'(a.ft),     32'(e.ft));
  endtask

  // Stimulus side: one clk, then queue what every DUT should show now.
  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      t     = 0;
      armed = 1'b1;
    end else begin
      t = t + 1;
    end
    if (armed) begin
      for (int d = 0; d < 3; d++) begin
        sb_q.push_back('{d: 2'(d), e: model(cfgs[d], t)});
      end
    end
  endtask

  always @(posedge clk) rst_q <= rst;

  // Monitor / aggregate state.
  int  ncyc = 0;
  bit  seen_rst = 1'b0;
  int  hs_low, br_low, last_lt, full_lines;
  bit  have_lt;
  int  vs_low, vb_cnt, ln_cnt, last_ft, fast_frames;
  bit  have_ft;
  item_t it;

  always @(negedge clk) begin
    ncyc++;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      cmp(int'(it.d), it.e, obs_a[it.d]);
    end

    if (rst_q === 1'b1) begin
      seen_rst = 1'b1;
      hs_low = 0; br_low = 0; have_lt = 1'b0; full_lines = 0;
      vs_low = 0; vb_cnt = 0; ln_cnt = 0; have_ft = 1'b0; fast_frames = 0;
    end

    if (seen_rst) begin
      // Full-timing line: sync width, blanking width and period in clks.
      if (!obs_a[0].hs) hs_low++;
      if (!obs_a[0].br) br_low++;
      if (obs_a[0].lt) begin
        chk("full.hsync_low_clks", 32'(hs_low), 32'd384);
        chk("full.bright_low_clks", 32'(br_low), 32'd640);
        if (have_lt) chk("full.line_period", 32'(ncyc - last_lt), 32'd3200);
        $display("full line %0d done at v=%0d: hsync_low=%0d bright_low=%0d",
                 full_lines, obs_a[0].v, hs_low, br_low);
        have_lt = 1'b1; last_lt = ncyc; hs_low = 0; br_low = 0; full_lines++;
      end

      // CLK_DIV=1, PREFETCH=0 instance: fetch tracks the current pixel.
      chk("fast.pix_const", 32'(obs_a[1].pix), 32'd1);
      chk("fast.fetch_h_eq_h", 32'(obs_a[1].fh), 32'(obs_a[1].h));
      chk("fast.fetch_v_eq_v", 32'(obs_a[1].fv), 32'(obs_a[1].v));
      chk("fast.valid_eq_bright", 32'(obs_a[1].fvalid), 32'(obs_a[1].br));
      if (!obs_a[1].vs) vs_low++;
      if (obs_a[1].vbt) vb_cnt++;
      if (obs_a[1].lt) ln_cnt++;
      if (obs_a[1].ft) begin
        chk("fast.frame_with_line", 32'(obs_a[1].lt), 32'd1);
        chk("fast.vsync_low_clks", 32'(vs_low), 32'd32);
        chk("fast.vblank_per_frame", 32'(vb_cnt), 32'd1);
        chk("fast.lines_per_frame", 32'(ln_cnt), 32'd10);
        if (have_ft) chk("fast.frame_period", 32'(ncyc - last_ft), 32'd160);
        $display("fast frame %0d done: vsync_low=%0d vblank=%0d lines=%0d",
                 fast_frames, vs_low, vb_cnt, ln_cnt);
        have_ft = 1'b1; last_ft = ncyc; vs_low = 0; vb_cnt = 0; ln_cnt = 0; fast_frames++;
      end

      // Hand-computed look-ahead vectors, checked once per pixel.
      for (int i = 0; i < vecs.size(); i++) begin
        if (obs_a[vecs[i].d].pix && (int'(obs_a[vecs[i].d].h) == vecs[i].h)
            && (int'(obs_a[vecs[i].d].v) == vecs[i].v)) begin
          chk($sformatf("vec%0d.fetch_h", i), 32'(obs_a[vecs[i].d].fh), 32'(vecs[i].fh));
          chk($sformatf("vec%0d.fetch_v", i), 32'(obs_a[vecs[i].d].fv), 32'(vecs[i].fv));
          chk($sformatf("vec%0d.fetch_valid", i), 32'(obs_a[vecs[i].d].fvalid), 32'(vecs[i].fval));
          seen[i] = 1'b1;
        end
      end
    end
  end

  initial begin
    cfgs[0] = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 2};
    cfgs[1] = '{1, 8, 2, 3, 3, 6, 1, 2, 1, 0};
    cfgs[2] = '{3, 8, 2, 3, 3, 6, 1, 2, 1, 2};

    vecs.push_back('{0, 798, 10, 0, 11, 1});
    vecs.push_back('{0, 638, 5, 640, 5, 0});
    vecs.push_back('{0, 0, 0, 2, 0, 1});
    vecs.push_back('{0, 799, 3, 1, 4, 1});
    vecs.push_back('{2, 15, 9, 1, 0, 1});
    vecs.push_back('{2, 6, 2, 8, 2, 0});
    vecs.push_back('{2, 14, 3, 0, 4, 1});
    vecs.push_back('{2, 15, 5, 1, 6, 0});
    vecs.push_back('{1, 7, 5, 7, 5, 1});
    vecs.push_back('{1, 8, 5, 8, 5, 0});

    rst = 1'b1;
    repeat (3) cyc();
    @(negedge clk) rst = 1'b0;
    $display("reset released, free run");
    repeat (1301) cyc();

    // Mid-raster reset at an arbitrary divider phase.
    @(negedge clk) rst = 1'b1;
    $display("mid-run reset at full hCount=%0d vCount=%0d", if_full.hCount, if_full.vCount);
    repeat (3) cyc();
    @(negedge clk) rst = 1'b0;
    repeat (36000) cyc();

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    chk("full.lines_after_reset", 32'(full_lines), 32'd11);
    chk("fast.frames_after_reset", 32'(fast_frames), 32'd225);
    for (int i = 0; i < vecs.size(); i++) begin
      chk($sformatf("vec%0d.reached", i), 32'(seen[i]), 32'd1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
